// File: rtl/vga_pkg.sv
// Shared timing constants, FSM state type and debug view for the VGA sync decoder.
// Build option VGA_RX_SYNC_EN (see vga_fall_detect) does not change anything here.
package vga_pkg;

  localparam int H_TOTAL      = 1600;
  localparam int H_DISP_START = 288;
  localparam int H_DISP       = 1280;
  localparam int V_TOTAL      = 521;
  localparam int V_DISP_START = 31;
  localparam int V_DISP       = 480;
  localparam int LOCK_FRAMES  = 2;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    MEASURE  = 2'd1,
    LOCKED   = 2'd2
  } vga_rx_state_t;

  // Internal state exposed for checkers and bring-up.
  typedef struct packed {
    vga_rx_state_t state;
    logic [10:0]   hcnt;
    logic [9:0]    vcnt;
    logic          hcnt_valid;
    logic          bad_frame;
    logic [3:0]    good_cnt;
  } vga_rx_dbg_t;

endpackage

// File: rtl/vga_fall_detect.sv
// Falling-edge detector for an active-low sync input. With VGA_RX_SYNC_EN defined the
// input first passes a 2-flop synchronizer (reset to 1), delaying the pulse by 2 cycles.
module vga_fall_detect
  import vga_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sync_n,
  output logic fall
);

  logic sig;
  logic prev;

`ifdef VGA_RX_SYNC_EN
  logic [1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) meta <= 2'b11;
    else       meta <= {meta[0], sync_n};
  end

  assign sig = meta[1];
`else
  assign sig = sync_n;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= sig;
  end

  assign fall = prev & ~sig;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side timing recovery: rebuilds h/v counters from HS/VS, checks line and
// frame lengths, locks after good frames. VGA_RX_SYNC_EN adds input synchronizers.
module vga_sync_decoder #(
  parameter int H_TOTAL      = vga_pkg::H_TOTAL,
  parameter int H_DISP_START = vga_pkg::H_DISP_START,
  parameter int H_DISP       = vga_pkg::H_DISP,
  parameter int V_TOTAL      = vga_pkg::V_TOTAL,
  parameter int V_DISP_START = vga_pkg::V_DISP_START,
  parameter int V_DISP       = vga_pkg::V_DISP,
  parameter int LOCK_FRAMES  = vga_pkg::LOCK_FRAMES
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                HS,
  input  logic                VS,
  output logic [9:0]          row,
  output logic [9:0]          col,
  output logic                de,
  output logic                locked,
  output logic                frame_start,
  output logic                line_err,
  output logic                frame_err,
  output vga_pkg::vga_rx_dbg_t dbg
);
  import vga_pkg::*;

  localparam logic [10:0] HCNT_MAX = 11'h7ff;
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT_LO = 11'(H_DISP_START);
  localparam logic [10:0] H_ACT_HI = 11'(H_DISP_START + H_DISP);
  localparam logic [9:0]  VCNT_MAX = 10'h3ff;
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT_LO = 10'(V_DISP_START);
  localparam logic [9:0]  V_ACT_HI = 10'(V_DISP_START + V_DISP);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

  logic          hs_fall, vs_fall;
  logic [10:0]   hcnt;
  logic [9:0]    vcnt;
  logic          hcnt_valid, bad_frame;
  logic [3:0]    good_cnt;
  vga_rx_state_t state;
  logic          hs_timeout, len_err, frame_good, h_act, v_act;

  vga_fall_detect u_hs_fall (.clk(CLOCK_50), .reset(reset), .sync_n(HS), .fall(hs_fall));
  vga_fall_detect u_vs_fall (.clk(CLOCK_50), .reset(reset), .sync_n(VS), .fall(vs_fall));

  // A fall arriving exactly at saturation means HS did show up, so it is not a timeout.
  assign hs_timeout  = (hcnt == HCNT_MAX) & ~hs_fall;
  assign len_err     = hs_fall & hcnt_valid & (hcnt != H_LAST);
  assign line_err    = len_err | (hs_timeout & (state != UNLOCKED));
  assign frame_err   = vs_fall & (state != UNLOCKED) & (vcnt != V_LAST);
  assign frame_good  = (vcnt == V_LAST) & ~bad_frame & ~line_err;
  assign frame_start = vs_fall;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hcnt       <= '0;
      vcnt       <= '0;
      hcnt_valid <= 1'b0;
      bad_frame  <= 1'b0;
    end else begin
      if (hs_fall)               hcnt <= '0;
      else if (hcnt != HCNT_MAX) hcnt <= hcnt + 11'd1;

      if (vs_fall)                          vcnt <= '0;
      else if (hs_fall && vcnt != VCNT_MAX) vcnt <= vcnt + 10'd1;

      if (hs_fall)         hcnt_valid <= 1'b1;
      else if (hs_timeout) hcnt_valid <= 1'b0;

      if (vs_fall)       bad_frame <= 1'b0;
      else if (line_err) bad_frame <= 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else if (hs_timeout) begin
      state    <= UNLOCKED;
      good_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (vs_fall) begin
            state    <= MEASURE;
            good_cnt <= '0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            if (!frame_good) begin
              good_cnt <= '0;
            end else if (good_cnt + 4'd1 >= LOCK_N) begin
              state    <= LOCKED;
              good_cnt <= '0;
              locked   <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 4'd1;
            end
          end
        end
        LOCKED: begin
          if (line_err || frame_err) begin
            state    <= MEASURE;
            good_cnt <= '0;
            locked   <= 1'b0;
          end
        end
        default: begin
          state    <= UNLOCKED;
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      endcase
    end
  end

  // Two CLOCK_50 cycles per pixel, hence the shift on the column.
  assign h_act = (hcnt >= H_ACT_LO) && (hcnt < H_ACT_HI);
  assign v_act = (vcnt >= V_ACT_LO) && (vcnt < V_ACT_HI);
  assign de    = locked & h_act & v_act;
  assign col   = de ? 10'((hcnt - H_ACT_LO) >> 1) : '0;
  assign row   = de ? (vcnt - V_ACT_LO) : '0;

  assign dbg = '{state: state, hcnt: hcnt, vcnt: vcnt, hcnt_valid: hcnt_valid,
                 bad_frame: bad_frame, good_cnt: good_cnt};

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on scaled-down timing; event scoreboard plus active-area probe.
// Works with or without VGA_RX_SYNC_EN (expected event times shift by LAT).
module tb_vga_sync_decoder;
  import vga_pkg::*;

  localparam int HT = 40, HDS = 8, HD = 24, VT = 12, VDS = 3, VD = 6;
  localparam int HSW = 4, VSL = 2;
`ifdef VGA_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam logic [3:0] EV_FS = 4'd1, EV_LERR = 4'd2, EV_FERR = 4'd3;
  localparam logic [3:0] EV_LOCK = 4'd4, EV_UNLOCK = 4'd5;

  // clock / reset
  logic clk = 1'b0;
  logic reset, hs, vs;
  logic [9:0] row, col;
  logic de, locked, frame_start, line_err, frame_err;
  vga_rx_dbg_t dbg;

  always #10 clk = ~clk;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_DISP_START(HDS), .H_DISP(HD), .V_TOTAL(VT),
    .V_DISP_START(VDS), .V_DISP(VD), .LOCK_FRAMES(2)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .HS(hs), .VS(vs), .row(row), .col(col), .de(de),
    .locked(locked), .frame_start(frame_start), .line_err(line_err),
    .frame_err(frame_err), .dbg(dbg)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] hist_q[$];
  logic mon_en = 1'b0, probe_block = 1'b0, locked_q = 1'b0;
  int unsigned last_line_start = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver
  task automatic drive_cycle(input logic h, input logic v, input logic r, input logic p,
                             input int l, input int c);
    @(posedge clk);
    #1;
    hs = h;
    vs = v;
    reset = r;
    hist_q.push_back({p, 15'(l), 16'(c)});
    if (hist_q.size() > 8) void'(hist_q.pop_front());
  endtask

  task automatic expect_ev(input logic [3:0] k, input int unsigned t);
    exp_q.push_back({k, 28'(t)});
  endtask

  // scoreboard
  task automatic take(input logic [3:0] k);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hffff_ffff;
    check_eq("event", {k, 28'(cyc)}, e);
  endtask

  always @(negedge clk) begin : monitor
    logic [31:0] e;
    int pl, pc;
    logic xde;
    if (mon_en) begin
      if (frame_start) take(EV_FS);
      if (line_err) take(EV_LERR);
      if (frame_err) take(EV_FERR);
      if (locked != locked_q) take(locked ? EV_LOCK : EV_UNLOCK);
      locked_q <= locked;
      if (hist_q.size() >= 2 + LAT) begin
        e = hist_q[hist_q.size() - 2 - LAT];
        if (e[31] && !probe_block) begin
          pl  = int'(e[30:16]);
          pc  = int'(e[15:0]);
          xde = (pc >= HDS) && (pc < HDS + HD) && (pl >= VDS) && (pl < VDS + VD);
          check_eq("de", de, xde);
          check_eq("row", row, xde ? 32'(pl - VDS) : 32'd0);
          check_eq("col", col, xde ? 32'((pc - HDS) >> 1) : 32'd0);
        end
      end
    end
  end

  task automatic run_frame(input int nlines, input int bad_line,
                           input logic [3:0] ev_a, input int off_a,
                           input logic [3:0] ev_b, input int off_b,
                           input logic probe, input int rst_line, input int rst_c);
    int len;
    logic r;
    probe_block = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == bad_line) ? HT - 2 : HT;
      for (int c = 0; c < len; c++) begin
        r = (l == rst_line) && (c == rst_c);
        if (r) probe_block = 1'b1;
        drive_cycle(c >= HSW, l >= VSL, r, probe && (l >= 1), l, c);
        if (c == 0) begin
          if (l == 0) begin
            expect_ev(EV_FS, cyc + LAT);
            if (ev_a != 4'd0) expect_ev(ev_a, cyc + LAT + off_a);
            if (ev_b != 4'd0) expect_ev(ev_b, cyc + LAT + off_b);
          end
          if (l == nlines - 1) last_line_start = cyc;
          if (bad_line >= 0 && l == bad_line + 1) begin
            expect_ev(EV_LERR, cyc + LAT);
            expect_ev(EV_UNLOCK, cyc + LAT + 1);
          end
        end
        if (r) begin
          expect_ev(EV_UNLOCK, cyc + 1);
          @(negedge clk);
          check_eq("row_before_reset", row, 2);
          check_eq("de_before_reset", de, 1);
        end
        if (l == 0 && c == 1 + LAT) begin
          @(negedge clk);
          check_eq("hcnt_after_fall", dbg.hcnt, 0);
          check_eq("vcnt_after_fall", dbg.vcnt, 0);
        end
        if (l == rst_line && c == rst_c + 1) begin
          @(negedge clk);
          check_eq("rst_row", row, 0);
          check_eq("rst_col", col, 0);
          check_eq("rst_de", de, 0);
          check_eq("rst_locked", locked, 0);
          check_eq("rst_hcnt", dbg.hcnt, 0);
          check_eq("rst_vcnt", dbg.vcnt, 0);
          check_eq("rst_state", 32'(dbg.state), 32'(UNLOCKED));
        end
      end
    end
  endtask

  initial begin : watchdog
    #(20 * 60000);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    hs = 1'b1;
    vs = 1'b1;
    reset = 1'b1;
    repeat (3) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check_eq("reset_row", row, 0);
    check_eq("reset_col", col, 0);
    check_eq("reset_de", de, 0);
    check_eq("reset_locked", locked, 0);
    check_eq("reset_frame_start", frame_start, 0);
    check_eq("reset_line_err", line_err, 0);
    check_eq("reset_frame_err", frame_err, 0);
    check_eq("reset_hcnt", dbg.hcnt, 0);
    check_eq("reset_vcnt", dbg.vcnt, 0);
    check_eq("reset_state", 32'(dbg.state), 32'(UNLOCKED));
    locked_q = 1'b0;
    mon_en = 1'b1;
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);

    // nominal timing: lock one cycle after the third VS fall
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, EV_LOCK, 1, 4'd0, 0, 1'b1, -1, -1);

    // short line while locked, then relock after two good frames
    run_frame(VT, 5, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, EV_LOCK, 1, 4'd0, 0, 1'b1, -1, -1);

    // short frame while locked
    run_frame(VT - 1, -1, 4'd0, 0, 4'd0, 0, 1'b1, -1, -1);
    run_frame(VT, -1, EV_FERR, 0, EV_UNLOCK, 1, 1'b0, -1, -1);
    @(negedge clk);
    check_eq("state_after_frame_err", 32'(dbg.state), 32'(MEASURE));
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, EV_LOCK, 1, 4'd0, 0, 1'b1, -1, -1);

    // HS timeout while locked
    expect_ev(EV_LERR, last_line_start + LAT + 2048);
    expect_ev(EV_UNLOCK, last_line_start + LAT + 2049);
    for (int i = 0; i < 2100; i++) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check_eq("state_after_timeout", 32'(dbg.state), 32'(UNLOCKED));
    check_eq("de_after_timeout", de, 0);
    check_eq("locked_after_timeout", locked, 0);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);

    // relocked frame with a reset in the middle of the active area
    run_frame(VT, -1, EV_LOCK, 1, 4'd0, 0, 1'b1, VDS + 2, HDS + 6);
    run_frame(VT, -1, 4'd0, 0, 4'd0, 0, 1'b0, -1, -1);
    @(negedge clk);
    check_eq("state_after_reset_frame", 32'(dbg.state), 32'(MEASURE));

    repeat (10) drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check_eq("exp_q_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
